// File: rtl/buff_uart_arbiter_if.sv
// Signal bundle between the requesters / buff_uart instance and buff_uart_arbiter.
// The master side is the environment (requesters plus UART); the slave side is the arbiter.
interface buff_uart_arbiter_if #(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned ADDRESS_WIDTH = 4
);
   logic [NUM_REQ-1:0]               req;
   logic [NUM_REQ-1:0]               req_we;
   logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr;
   logic [NUM_REQ*WIDTH-1:0]         req_wdata;
   logic [NUM_REQ-1:0]               ack;
   logic [NUM_REQ-1:0]               err;
   logic [WIDTH-1:0]                 rdata;
   logic                             busy;
   logic [ADDRESS_WIDTH-1:0]         uart_active_address;
   logic                             uart_read_enable;
   logic                             uart_write_enable;
   logic [WIDTH-1:0]                 uart_wdata;
   logic [WIDTH-1:0]                 uart_rdata;

   modport master (
      output req, req_we, req_addr, req_wdata, uart_rdata,
      input  ack, err, rdata, busy,
      input  uart_active_address, uart_read_enable, uart_write_enable, uart_wdata
   );

   modport slave (
      input  req, req_we, req_addr, req_wdata, uart_rdata,
      output ack, err, rdata, busy,
      output uart_active_address, uart_read_enable, uart_write_enable, uart_wdata
   );
endinterface

// File: rtl/buff_uart_arbiter.sv
// Round-robin arbiter sharing one buffered UART register port among NUM_REQ requesters,
// sequencing one single-word RX read or TX write at a time.
module buff_uart_arbiter #(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned ADDRESS_WIDTH = 4,
   parameter int unsigned RX_ADDRESS    = 0,
   parameter int unsigned TX_ADDRESS    = 0,
   parameter int unsigned READ_LATENCY  = 1
) (
   input logic                clk,
   input logic                rst_n,
   buff_uart_arbiter_if.slave bus
);
   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(READ_LATENCY + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t                   state_q,      state_d;
   logic [IDX_W-1:0]         last_grant_q, last_grant_d;
   logic [IDX_W-1:0]         idx_q,        idx_d;
   logic                     we_q,         we_d;
   logic [CNT_W-1:0]         cnt_q,        cnt_d;
   logic [NUM_REQ-1:0]       ack_q,        ack_d;
   logic [NUM_REQ-1:0]       err_q,        err_d;
   logic [WIDTH-1:0]         rdata_q,      rdata_d;
   logic                     busy_q,       busy_d;
   logic [ADDRESS_WIDTH-1:0] uart_addr_q,  uart_addr_d;
   logic                     uart_re_q,    uart_re_d;
   logic                     uart_we_q,    uart_we_d;
   logic [WIDTH-1:0]         uart_wdata_q, uart_wdata_d;

   logic                     grant_found;
   logic [IDX_W-1:0]         grant_idx;
   logic [IDX_W-1:0]         cand;
   logic                     sel_we;
   logic [ADDRESS_WIDTH-1:0] sel_addr;
   logic [WIDTH-1:0]         sel_wdata;
   logic                     sel_legal;

   // Round-robin search: first set req bit after last_grant, wrapping.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         cand = IDX_W'((32'(last_grant_q) + off) % NUM_REQ);
         if (!grant_found && bus.req[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Select the granted requester's transaction fields.
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == IDX_W'(i)) begin
            sel_we    = bus.req_we[i];
            sel_addr  = bus.req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            sel_wdata = bus.req_wdata[i*WIDTH +: WIDTH];
         end
      end
   end

   assign sel_legal = (sel_addr == (sel_we ? ADDRESS_WIDTH'(TX_ADDRESS)
                                           : ADDRESS_WIDTH'(RX_ADDRESS)));

   // Output registers are loaded from the upcoming state so they align with it.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      idx_d        = idx_q;
      we_d         = we_q;
      cnt_d        = cnt_q;
      ack_d        = '0;
      err_d        = '0;
      rdata_d      = '0;
      uart_addr_d  = '0;
      uart_re_d    = 1'b0;
      uart_we_d    = 1'b0;
      uart_wdata_d = '0;

      case (state_q)
         ST_IDLE: begin
            if (grant_found) begin
               idx_d = grant_idx;
               we_d  = sel_we;
               cnt_d = '0;
               if (sel_legal) begin
                  state_d      = ST_ISSUE;
                  uart_addr_d  = sel_addr;
                  uart_re_d    = !sel_we;
                  uart_we_d    = sel_we;
                  uart_wdata_d = sel_wdata;
               end else begin
                  state_d          = ST_RESP;
                  ack_d[grant_idx] = 1'b1;
                  err_d[grant_idx] = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            if (we_q) begin
               state_d      = ST_RESP;
               ack_d[idx_q] = 1'b1;
            end else begin
               state_d = ST_WAIT;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (cnt_q == CNT_W'(READ_LATENCY)) begin
               state_d      = ST_RESP;
               ack_d[idx_q] = 1'b1;
               rdata_d      = bus.uart_rdata;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            last_grant_d = idx_q;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= IDX_W'(NUM_REQ - 1);
         idx_q        <= '0;
         we_q         <= 1'b0;
         cnt_q        <= '0;
         ack_q        <= '0;
         err_q        <= '0;
         rdata_q      <= '0;
         busy_q       <= 1'b0;
         uart_addr_q  <= '0;
         uart_re_q    <= 1'b0;
         uart_we_q    <= 1'b0;
         uart_wdata_q <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         idx_q        <= idx_d;
         we_q         <= we_d;
         cnt_q        <= cnt_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
         rdata_q      <= rdata_d;
         busy_q       <= busy_d;
         uart_addr_q  <= uart_addr_d;
         uart_re_q    <= uart_re_d;
         uart_we_q    <= uart_we_d;
         uart_wdata_q <= uart_wdata_d;
      end
   end

   assign bus.ack                 = ack_q;
   assign bus.err                 = err_q;
   assign bus.rdata               = rdata_q;
   assign bus.busy                = busy_q;
   assign bus.uart_active_address = uart_addr_q;
   assign bus.uart_read_enable    = uart_re_q;
   assign bus.uart_write_enable   = uart_we_q;
   assign bus.uart_wdata          = uart_wdata_q;

endmodule

// File: tb/tb_buff_uart_arbiter.sv
// Self-checking bench for buff_uart_arbiter: directed scenarios plus randomized
// request traffic against a transaction-level round-robin / latency model.
module tb_buff_uart_arbiter;
   localparam int NR  = 4;
   localparam int W   = 8;
   localparam int AW  = 4;
   localparam int RXA = 0;
   localparam int TXA = 0;
   localparam int RL  = 1;

   logic         clk = 1'b0;
   logic         rst_n;
   int           errors = 0;
   int           checks = 0;
   int           exp_last;
   logic [W-1:0] next_rd_val;

   buff_uart_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .ADDRESS_WIDTH(AW)) bus ();

   buff_uart_arbiter #(
      .NUM_REQ(NR), .WIDTH(W), .ADDRESS_WIDTH(AW),
      .RX_ADDRESS(RXA), .TX_ADDRESS(TXA), .READ_LATENCY(RL)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // UART model: presents next_rd_val exactly RL cycles after read_enable, noise otherwise.
   initial begin
      int k;
      logic [W-1:0] v;
      k = 0;
      v = '0;
      bus.uart_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (k > 0) begin
            k--;
            bus.uart_rdata = (k == 0) ? v : W'($urandom);
         end else begin
            bus.uart_rdata = W'($urandom);
         end
         if (bus.uart_read_enable === 1'b1) begin
            k = RL;
            v = next_rd_val;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clear_req();
      bus.req       = '0;
      bus.req_we    = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
   endtask

   task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
      bus.req[i]              = 1'b1;
      bus.req_we[i]           = we;
      bus.req_addr[i*AW +: AW] = a;
      bus.req_wdata[i*W +: W]  = d;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_req();
      tick(); tick();
      rst_n = 1'b1;
      tick();
      exp_last = NR - 1;
   endtask

   function automatic int rr_pick(input logic [NR-1:0] r, input int last);
      for (int o = 1; o <= NR; o++) begin
         if (r[(last + o) % NR] == 1'b1) return (last + o) % NR;
      end
      return -1;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      clear_req();
      tick(); tick();
      checks++; if (bus.ack !== 4'b0 || bus.err !== 4'b0) begin errors++; $display("FAIL reset_ack_err: ack=%b err=%b want 0", bus.ack, bus.err); end
      checks++; if (bus.rdata !== 8'h00 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_rdata_busy: rdata=%h busy=%b want 0", bus.rdata, bus.busy); end
      checks++; if (bus.uart_read_enable !== 1'b0 || bus.uart_write_enable !== 1'b0) begin errors++; $display("FAIL reset_enables: re=%b we=%b want 0", bus.uart_read_enable, bus.uart_write_enable); end
      checks++; if (bus.uart_active_address !== 4'h0 || bus.uart_wdata !== 8'h00) begin errors++; $display("FAIL reset_uart_bus: addr=%h wdata=%h want 0", bus.uart_active_address, bus.uart_wdata); end
      rst_n = 1'b1;
      tick();
      exp_last = NR - 1;
   endtask

   task automatic test_single_write();
      set_req(0, 1'b1, AW'(TXA), 8'hA5);
      tick();
      checks++; if (bus.uart_write_enable !== 1'b1 || bus.uart_read_enable !== 1'b0) begin errors++; $display("FAIL wr_enables: re=%b we=%b want re=0 we=1", bus.uart_read_enable, bus.uart_write_enable); end
      checks++; if (bus.uart_wdata !== 8'hA5 || bus.uart_active_address !== AW'(TXA)) begin errors++; $display("FAIL wr_bus: wdata=%h addr=%h want a5/%h", bus.uart_wdata, bus.uart_active_address, AW'(TXA)); end
      checks++; if (bus.ack !== 4'b0000 || bus.busy !== 1'b1) begin errors++; $display("FAIL wr_issue_state: ack=%b busy=%b want 0000/1", bus.ack, bus.busy); end
      tick();
      checks++; if (bus.ack !== 4'b0001 || bus.err !== 4'b0000) begin errors++; $display("FAIL wr_ack: ack=%b err=%b want 0001/0000", bus.ack, bus.err); end
      checks++; if (bus.uart_write_enable !== 1'b0 || bus.uart_wdata !== 8'h00 || bus.rdata !== 8'h00) begin errors++; $display("FAIL wr_resp_bus: we=%b wdata=%h rdata=%h want 0", bus.uart_write_enable, bus.uart_wdata, bus.rdata); end
      clear_req();
      tick();
      checks++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0000) begin errors++; $display("FAIL wr_idle: busy=%b ack=%b want 0", bus.busy, bus.ack); end
      exp_last = 0;
   endtask

   task automatic test_single_read();
      next_rd_val = 8'h3C;
      set_req(1, 1'b0, AW'(RXA), 8'h77);
      tick();
      checks++; if (bus.uart_read_enable !== 1'b1 || bus.uart_write_enable !== 1'b0 || bus.uart_active_address !== AW'(RXA)) begin errors++; $display("FAIL rd_issue: re=%b we=%b addr=%h want 1/0/%h", bus.uart_read_enable, bus.uart_write_enable, bus.uart_active_address, AW'(RXA)); end
      for (int c = 0; c < RL; c++) begin
         tick();
         checks++; if (bus.ack !== 4'b0000 || bus.busy !== 1'b1 || bus.uart_read_enable !== 1'b0) begin errors++; $display("FAIL rd_wait: ack=%b busy=%b re=%b want 0000/1/0", bus.ack, bus.busy, bus.uart_read_enable); end
      end
      tick();
      checks++; if (bus.ack !== 4'b0010 || bus.err !== 4'b0000) begin errors++; $display("FAIL rd_ack: ack=%b err=%b want 0010/0000", bus.ack, bus.err); end
      checks++; if (bus.rdata !== 8'h3C) begin errors++; $display("FAIL rd_data: rdata=%h want 3c", bus.rdata); end
      clear_req();
      tick();
      checks++; if (bus.rdata !== 8'h00 || bus.busy !== 1'b0) begin errors++; $display("FAIL rd_idle: rdata=%h busy=%b want 0", bus.rdata, bus.busy); end
      exp_last = 1;
   endtask

   task automatic test_fairness();
      do_reset();
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(TXA), 8'(8'h10 + i));
      for (int k = 0; k <= NR; k++) begin
         int w;
         logic [NR-1:0] exp_ack;
         w = rr_pick(bus.req, exp_last);
         exp_ack = '0;
         exp_ack[w] = 1'b1;
         tick();
         checks++; if (bus.uart_write_enable !== 1'b1 || bus.uart_read_enable !== 1'b0 || bus.uart_wdata !== 8'(8'h10 + w)) begin errors++; $display("FAIL fair_issue%0d: we=%b re=%b wdata=%h want 1/0/%h", k, bus.uart_write_enable, bus.uart_read_enable, bus.uart_wdata, 8'(8'h10 + w)); end
         tick();
         checks++; if (bus.ack !== exp_ack || bus.busy !== 1'b1) begin errors++; $display("FAIL fair_ack%0d: ack=%b busy=%b want %b/1", k, bus.ack, bus.busy, exp_ack); end
         exp_last = w;
         tick();
         checks++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0000) begin errors++; $display("FAIL fair_gap%0d: busy=%b ack=%b want 0", k, bus.busy, bus.ack); end
      end
      clear_req();
   endtask

   task automatic test_illegal();
      set_req(2, 1'b1, AW'(TXA + 1), 8'h5A);
      tick();
      checks++; if (bus.ack !== 4'b0100 || bus.err !== 4'b0100) begin errors++; $display("FAIL ill_ack_err: ack=%b err=%b want 0100/0100", bus.ack, bus.err); end
      checks++; if (bus.uart_read_enable !== 1'b0 || bus.uart_write_enable !== 1'b0 || bus.rdata !== 8'h00) begin errors++; $display("FAIL ill_no_access: re=%b we=%b rdata=%h want 0", bus.uart_read_enable, bus.uart_write_enable, bus.rdata); end
      clear_req();
      tick();
      checks++; if (bus.ack !== 4'b0000 || bus.err !== 4'b0000 || bus.busy !== 1'b0) begin errors++; $display("FAIL ill_idle: ack=%b err=%b busy=%b want 0", bus.ack, bus.err, bus.busy); end
      exp_last = 2;
   endtask

   task automatic test_req_change();
      next_rd_val = 8'hC3;
      set_req(2, 1'b0, AW'(RXA), 8'h00);
      tick();
      bus.req[2]               = 1'b0;
      bus.req_we[2]            = 1'b1;
      bus.req_addr[2*AW +: AW] = AW'(RXA + 9);
      checks++; if (bus.uart_active_address !== AW'(RXA) || bus.uart_read_enable !== 1'b1) begin errors++; $display("FAIL chg_issue: addr=%h re=%b want %h/1", bus.uart_active_address, bus.uart_read_enable, AW'(RXA)); end
      for (int c = 0; c < RL; c++) tick();
      tick();
      checks++; if (bus.ack !== 4'b0100 || bus.err !== 4'b0000 || bus.rdata !== 8'hC3) begin errors++; $display("FAIL chg_ack: ack=%b err=%b rdata=%h want 0100/0000/c3", bus.ack, bus.err, bus.rdata); end
      clear_req();
      tick();
      exp_last = 2;
   endtask

   task automatic test_reset_mid_read();
      next_rd_val = 8'h99;
      set_req(0, 1'b0, AW'(RXA), 8'h00);
      tick(); tick();
      rst_n = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0000 || bus.err !== 4'b0000) begin errors++; $display("FAIL rst_mid_state: busy=%b ack=%b err=%b want 0", bus.busy, bus.ack, bus.err); end
      checks++; if (bus.uart_read_enable !== 1'b0 || bus.uart_write_enable !== 1'b0 || bus.uart_active_address !== 4'h0) begin errors++; $display("FAIL rst_mid_uart: re=%b we=%b addr=%h want 0", bus.uart_read_enable, bus.uart_write_enable, bus.uart_active_address); end
      tick(); tick();
      clear_req();
      rst_n = 1'b1;
      exp_last = NR - 1;
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++; if (bus.ack !== 4'b0000 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_no_ack%0d: ack=%b busy=%b want 0", c, bus.ack, bus.busy); end
      end
      set_req(0, 1'b1, AW'(TXA), 8'h11);
      set_req(3, 1'b1, AW'(TXA), 8'h33);
      tick();
      checks++; if (bus.uart_wdata !== 8'h11 || bus.uart_write_enable !== 1'b1) begin errors++; $display("FAIL rst_first_issue: wdata=%h we=%b want 11/1", bus.uart_wdata, bus.uart_write_enable); end
      tick();
      checks++; if (bus.ack !== 4'b0001) begin errors++; $display("FAIL rst_first_ack: ack=%b want 0001", bus.ack); end
      bus.req[0] = 1'b0;
      tick();
      tick();
      checks++; if (bus.uart_wdata !== 8'h33 || bus.uart_write_enable !== 1'b1) begin errors++; $display("FAIL rst_second_issue: wdata=%h we=%b want 33/1", bus.uart_wdata, bus.uart_write_enable); end
      tick();
      checks++; if (bus.ack !== 4'b1000) begin errors++; $display("FAIL rst_second_ack: ack=%b want 1000", bus.ack); end
      clear_req();
      tick();
      exp_last = 3;
   endtask

   task automatic test_random();
      bit           pend[NR];
      logic         pwe[NR];
      logic [AW-1:0] pad[NR];
      logic [W-1:0] pwd[NR];
      for (int i = 0; i < NR; i++) pend[i] = 1'b0;
      for (int t = 0; t < 200; t++) begin
         int w, lat;
         bit legal;
         logic [NR-1:0] pv, exp_ack, exp_err;
         logic [AW-1:0] legal_addr;
         logic [W-1:0] exp_rdata;
         for (int i = 0; i < NR; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i]    = 1'b1;
               pwe[i]     = 1'($urandom_range(0, 1));
               legal_addr = pwe[i] ? AW'(TXA) : AW'(RXA);
               pad[i]     = ($urandom_range(0, 4) == 0) ? (legal_addr ^ AW'($urandom_range(1, (1 << AW) - 1))) : legal_addr;
               pwd[i]     = W'($urandom);
               set_req(i, pwe[i], pad[i], pwd[i]);
            end
         end
         next_rd_val = W'($urandom);
         checks++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0000) begin errors++; $display("FAIL rnd_idle%0d: busy=%b ack=%b want 0", t, bus.busy, bus.ack); end
         for (int i = 0; i < NR; i++) pv[i] = pend[i];
         w = rr_pick(pv, exp_last);
         if (w < 0) begin
            tick();
            continue;
         end
         legal     = (pad[w] == (pwe[w] ? AW'(TXA) : AW'(RXA)));
         lat       = !legal ? 1 : (pwe[w] ? 2 : 2 + RL);
         exp_ack   = '0;
         exp_ack[w] = 1'b1;
         exp_err   = legal ? 4'b0000 : exp_ack;
         exp_rdata = (legal && !pwe[w]) ? next_rd_val : 8'h00;
         for (int n = 1; n <= lat; n++) begin
            tick();
            if (n == 1 && lat > 1 && $urandom_range(0, 1) == 1) begin
               bus.req_we[w]            = ~pwe[w];
               bus.req_addr[w*AW +: AW] = AW'($urandom);
               bus.req_wdata[w*W +: W]  = W'($urandom);
               if ($urandom_range(0, 1) == 1) bus.req[w] = 1'b0;
            end
            if (n == 1 && legal) begin
               checks++; if (bus.uart_read_enable !== !pwe[w] || bus.uart_write_enable !== pwe[w] || bus.uart_active_address !== pad[w] || bus.uart_wdata !== pwd[w]) begin errors++; $display("FAIL rnd_issue%0d: re=%b we=%b addr=%h wdata=%h want %b/%b/%h/%h", t, bus.uart_read_enable, bus.uart_write_enable, bus.uart_active_address, bus.uart_wdata, !pwe[w], pwe[w], pad[w], pwd[w]); end
            end else begin
               checks++; if (bus.uart_read_enable !== 1'b0 || bus.uart_write_enable !== 1'b0 || bus.uart_active_address !== 4'h0 || bus.uart_wdata !== 8'h00) begin errors++; $display("FAIL rnd_quiet%0d.%0d: re=%b we=%b addr=%h wdata=%h want 0", t, n, bus.uart_read_enable, bus.uart_write_enable, bus.uart_active_address, bus.uart_wdata); end
            end
            if (n < lat) begin
               checks++; if (bus.ack !== 4'b0000 || bus.err !== 4'b0000 || bus.busy !== 1'b1) begin errors++; $display("FAIL rnd_pending%0d.%0d: ack=%b err=%b busy=%b want 0/0/1", t, n, bus.ack, bus.err, bus.busy); end
            end else begin
               checks++; if (bus.ack !== exp_ack || bus.err !== exp_err || bus.rdata !== exp_rdata || bus.busy !== 1'b1) begin errors++; $display("FAIL rnd_resp%0d: ack=%b err=%b rdata=%h busy=%b want %b/%b/%h/1", t, bus.ack, bus.err, bus.rdata, bus.busy, exp_ack, exp_err, exp_rdata); end
            end
         end
         pend[w]    = 1'b0;
         bus.req[w] = 1'b0;
         exp_last   = w;
         tick();
      end
      clear_req();
      tick();
   endtask

   initial begin
      rst_n       = 1'b0;
      next_rd_val = '0;
      exp_last    = NR - 1;
      clear_req();
      test_reset();
      test_single_write();
      test_single_read();
      test_fairness();
      test_illegal();
      test_req_change();
      test_reset_mid_read();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/buff_uart_arbiter.md
Name: buff_uart_arbiter

Overview:
Shares one buffered UART's register port (active_address, read_enable, write_enable, data) among NUM_REQ requesters. Each requester may issue a single-word read from the RX FIFO address or a single-word write to the TX FIFO address. Selection is round-robin, and the block sequences exactly one bus transaction at a time. It sits between the processing masters and the buff_uart instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 8, data word width; matches UART width
ADDRESS_WIDTH, 4, UART address width
RX_ADDRESS, 0, only legal read address
TX_ADDRESS, 0, only legal write address
READ_LATENCY, 1, cycles from read_enable high to valid uart_rdata (1..4)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester request; held high until ack
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDRESS_WIDTH  per-requester address, slice i = requester i
req_wdata  in  NUM_REQ*WIDTH  per-requester write data
ack  out  NUM_REQ  one-cycle completion pulse, one-hot
err  out  NUM_REQ  one-cycle illegal-address pulse, coincident with ack
rdata  out  WIDTH  read data, valid in the ack cycle
busy  out  1  high when state != IDLE
uart_active_address  out  ADDRESS_WIDTH  to UART
uart_read_enable  out  1  to UART
uart_write_enable  out  1  to UART
uart_wdata  out  WIDTH  to UART write data
uart_rdata  in  WIDTH  UART data output

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous assert and synchronous deassert, active-low (rst_n).
- Reset values: all outputs 0, state IDLE, round-robin pointer last_grant = NUM_REQ-1 (so requester 0 wins first), latched transaction registers 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise grant the first set req bit searching from last_grant+1 upward, with wrap.
  - Latch index, we, addr and wdata into registers.
  - Legality: addr == (we ? TX_ADDRESS : RX_ADDRESS) -> ISSUE. Any other addr -> RESP with err flag set; no UART access occurs.
- ISSUE (exactly 1 cycle):
  - Drive uart_active_address = latched addr.
  - Drive uart_read_enable = !we or uart_write_enable = we; the other enable stays low.
  - Drive uart_wdata = latched wdata.
  - Next state: WAIT for reads, RESP for writes.
- WAIT (reads only):
  - Counter runs from 1 to READ_LATENCY; the ISSUE cycle counts as cycle 0.
  - When count == READ_LATENCY, capture uart_rdata into rdata_q and go to RESP.
  - The enables are low throughout WAIT.
- RESP (1 cycle):
  - ack[idx] = 1 and err[idx] = err flag.
  - rdata = rdata_q for reads, 0 for writes and errors.
  - last_grant <= idx, then go to IDLE.
- Enables: uart_read_enable and uart_write_enable are never high together and are each high for at most one cycle per transaction. uart_active_address and uart_wdata return to 0 outside ISSUE.
- Latency: from req sampled in IDLE to ack:
  - Write: 3 cycles (IDLE, ISSUE, RESP).
  - Read: 3 + READ_LATENCY cycles.
  - Error: 2 cycles.
- Back-to-back: after RESP the FSM re-enters IDLE, so there is at least one IDLE cycle between transactions. A requester whose req is still high after ack starts a new transaction only when the round-robin search reaches it again.
- Request changes:
  - req deasserted after grant: the latched transaction still completes and ack is still pulsed.
  - req_we, req_addr or req_wdata changed after grant: ignored, because the values are latched.
- Simultaneous requests: exactly one grant per arbitration. No requester waits more than NUM_REQ-1 transactions.
- Reset mid-operation: the FSM aborts immediately and the enables drop asynchronously. No ack is issued for the aborted transaction. The pointer returns to its reset value.
- Width rules: requester slice i occupies bits [i*W +: W]. The counter width is $clog2(READ_LATENCY+1).

Test Plan:
- Single write: reset, req=0001, we=1, addr=TX_ADDRESS, wdata=0xA5 -> uart_write_enable high 1 cycle with wdata 0xA5; ack=0001 three cycles after the request is sampled; err=0.
- Single read, READ_LATENCY=1: req=0010, we=0, addr=RX_ADDRESS, UART returns 0x3C one cycle after read_enable -> rdata=0x3C with ack=0010 four cycles after the request is sampled.
- Fairness: req=1111 held continuously with writes -> grants in order 0,1,2,3,0; no enable overlap; busy drops for exactly one cycle between transactions.
- Illegal address: we=1, addr=TX_ADDRESS+1 -> ack and err pulse together two cycles after the request is sampled; uart_read_enable and uart_write_enable stay 0.
- Request change after grant: requester 2 read granted, req[2] dropped and req_addr changed in the ISSUE cycle -> UART sees the original address; ack[2] is still pulsed.
- Reset mid-read: rst_n low during WAIT -> all outputs 0 immediately, no ack; after release, req=1000 is serviced first ahead of req=0001 only if its request arrives alone; with req=1001 requester 0 is granted first.
